// File: rtl/i2c_pkg.sv
// Shared I2C definitions: command codes and bit-engine FSM states,
// also used by the byte controller above the bit engine.
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WR    = 2'd2;
    localparam logic [1:0] CMD_RD    = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        ST_A,
        ST_B,
        RS_LOW,
        RS_HIGH,
        BIT_LOW,
        BIT_HIGH,
        SP_LOW,
        SP_HIGH,
        SP_FREE
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for a deglitched I2C line level.
// Resets to 1, the idle level of an open-drain bus.
module i2c_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_bit_tx.sv
// Bit-level I2C transmit engine: times SCL/SDA pull-down enables for START,
// STOP, WR and RD, waits out clock stretching and detects lost arbitration.
//   IDLE     | waiting for a command     ST_A/ST_B  | SDA low, then SCL low
//   RS_LOW   | SCL low, SDA released     RS_HIGH    | SCL released, timing THIGH
//   BIT_LOW  | SCL low, SDA set up       BIT_HIGH   | SCL released, sampling SDA
//   SP_LOW   | SCL and SDA low           SP_HIGH/SP_FREE | SCL up, then SDA up
module i2c_bit_tx
    import i2c_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic             cmd_bit,
    output logic             rsp_valid,
    output logic             rsp_bit,
    output logic             arb_lost,
    output logic             busy,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             scl_oe,
    output logic             sda_oe,
    input  logic [CNT_W-1:0] tlow,
    input  logic [CNT_W-1:0] thigh,
    input  logic [CNT_W-1:0] thold
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic scl_s, sda_s;

    i2c_sync2 u_scl_sync (.clk(clk), .rst_n(rstb), .d(scl_in), .q(scl_s));
    i2c_sync2 u_sda_sync (.clk(clk), .rst_n(rstb), .d(sda_in), .q(sda_s));

    i2c_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tlow_q, tlow_d, thigh_q, thigh_d, thold_q, thold_d;
    logic             wr_q, wr_d, bit_q, bit_d;
    logic             scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic             rdy_q, rdy_d, rsp_valid_q, rsp_valid_d;
    logic             rsp_bit_q, rsp_bit_d, arb_q, arb_d, busy_q, busy_d;

    logic [CNT_W-1:0] tlow_in, thigh_in, thold_in, hold_in, hold_eff, elapsed;
    logic             cnt_last;

    assign tlow_in  = (tlow  == '0) ? ONE : tlow;
    assign thigh_in = (thigh == '0) ? ONE : thigh;
    assign thold_in = (thold == '0) ? ONE : thold;
    // SDA must settle before SCL is released, so the hold is capped at TLOW-1.
    assign hold_in  = (thold_in < tlow_in) ? thold_in : tlow_in - ONE;
    assign hold_eff = (thold_q < tlow_q) ? thold_q : tlow_q - ONE;
    assign elapsed  = tlow_q - cnt_q;
    assign cnt_last = (cnt_q == ONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tlow_d      = tlow_q;
        thigh_d     = thigh_q;
        thold_d     = thold_q;
        wr_d        = wr_q;
        bit_d       = bit_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rsp_valid_d = 1'b0;
        rsp_bit_d   = rsp_bit_q;
        arb_d       = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tlow_d  = tlow_in;
                    thigh_d = thigh_in;
                    thold_d = thold_in;
                    wr_d    = (cmd == CMD_WR);
                    bit_d   = cmd_bit;
                    if (cmd == CMD_START) begin
                        if (busy_q) begin
                            state_d  = RS_LOW;
                            cnt_d    = tlow_in;
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b0;
                        end else begin
                            state_d  = ST_A;
                            cnt_d    = thigh_in;
                            busy_d   = 1'b1;
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b1;
                        end
                    end else if (busy_q && cmd == CMD_STOP) begin
                        state_d  = SP_LOW;
                        cnt_d    = tlow_in;
                        scl_oe_d = 1'b1;
                        sda_oe_d = 1'b1;
                    end else if (busy_q) begin
                        state_d  = BIT_LOW;
                        cnt_d    = tlow_in;
                        scl_oe_d = 1'b1;
                        if (hold_in == '0) sda_oe_d = (cmd == CMD_WR) ? ~cmd_bit : 1'b0;
                    end
                end
            end
            ST_A: begin
                if (cnt_last) begin
                    state_d  = ST_B;
                    cnt_d    = thold_q;
                    scl_oe_d = 1'b1;
                end else cnt_d = cnt_q - ONE;
            end
            ST_B: begin
                if (cnt_last) state_d = IDLE;
                else cnt_d = cnt_q - ONE;
            end
            RS_LOW: begin
                if (cnt_last) begin
                    state_d  = RS_HIGH;
                    cnt_d    = thigh_q;
                    scl_oe_d = 1'b0;
                end else cnt_d = cnt_q - ONE;
            end
            RS_HIGH: begin
                if (scl_s) begin
                    if (cnt_last) begin
                        state_d  = ST_A;
                        cnt_d    = thigh_q;
                        sda_oe_d = 1'b1;
                    end else cnt_d = cnt_q - ONE;
                end
            end
            BIT_LOW: begin
                if ((elapsed + ONE) >= hold_eff) sda_oe_d = wr_q ? ~bit_q : 1'b0;
                if (cnt_last) begin
                    state_d  = BIT_HIGH;
                    cnt_d    = thigh_q;
                    scl_oe_d = 1'b0;
                end else cnt_d = cnt_q - ONE;
            end
            BIT_HIGH: begin
                // Counter only runs once SCL is seen high, so stretching just pauses it.
                if (scl_s) begin
                    if (wr_q && bit_q && !sda_s) begin
                        state_d     = IDLE;
                        scl_oe_d    = 1'b0;
                        sda_oe_d    = 1'b0;
                        busy_d      = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_bit_d   = 1'b0;
                        arb_d       = 1'b1;
                    end else if (cnt_last) begin
                        state_d     = IDLE;
                        scl_oe_d    = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_bit_d   = sda_s;
                    end else cnt_d = cnt_q - ONE;
                end
            end
            SP_LOW: begin
                if (cnt_last) begin
                    state_d  = SP_HIGH;
                    cnt_d    = thigh_q;
                    scl_oe_d = 1'b0;
                end else cnt_d = cnt_q - ONE;
            end
            SP_HIGH: begin
                if (scl_s) begin
                    if (cnt_last) begin
                        state_d  = SP_FREE;
                        cnt_d    = thigh_q;
                        sda_oe_d = 1'b0;
                    end else cnt_d = cnt_q - ONE;
                end
            end
            SP_FREE: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else cnt_d = cnt_q - ONE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tlow_q      <= ONE;
            thigh_q     <= ONE;
            thold_q     <= ONE;
            wr_q        <= 1'b0;
            bit_q       <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rdy_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            arb_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tlow_q      <= tlow_d;
            thigh_q     <= thigh_d;
            thold_q     <= thold_d;
            wr_q        <= wr_d;
            bit_q       <= bit_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rdy_q       <= rdy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            arb_q       <= arb_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign arb_lost  = arb_q;
    assign busy      = busy_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_tx.sv
// Directed bench for i2c_bit_tx: open-drain line model, scoreboard of expected
// bit responses, and timing checks on the line enables.
module tb_i2c_bit_tx;
    import i2c_pkg::*;

    localparam int TL  = 4;
    localparam int TH  = 4;
    localparam int THD = 1;
    localparam int LAT = TL + TH + 2;

    logic       clk = 1'b0;
    logic       rstb;
    logic       cmd_valid, cmd_ready, cmd_bit;
    logic [1:0] cmd;
    logic       rsp_valid, rsp_bit, arb_lost, busy;
    logic       scl_in, sda_in, scl_oe, sda_oe;
    logic [7:0] tlow, thigh, thold;
    logic       scl_hold, sda_hold;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct packed {
        logic rbit;
        logic arb;
        int   lat;
    } exp_t;
    exp_t  sb[$];
    string sb_tag[$];

    i2c_bit_tx #(.CNT_W(8)) dut (
        .clk(clk), .rstb(rstb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_bit(cmd_bit),
        .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .arb_lost(arb_lost), .busy(busy),
        .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .tlow(tlow), .thigh(thigh), .thold(thold)
    );

    // Open-drain bus: a line is low if the DUT or the bench pulls it.
    assign scl_in = ~(scl_oe | scl_hold);
    assign sda_in = ~(sda_oe | sda_hold);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic b);
        chk_b("cmd_ready before issue", cmd_ready, 1'b1);
        cmd       = c;
        cmd_bit   = b;
        cmd_valid = 1'b1;
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) tick();
    endtask

    // Issue a WR/RD, push its expected response, and check SDA holds for THOLD
    // cycles after SCL falls before taking the new value.
    task automatic start_bit(input logic [1:0] c, input logic b, input logic sda_before,
                             input logic ebit, input logic earb, input int elat,
                             input string tag);
        exp_t e;
        logic drv;
        e.rbit = ebit;
        e.arb  = earb;
        e.lat  = elat;
        sb.push_back(e);
        sb_tag.push_back(tag);
        drv = (c == CMD_WR) ? ~b : 1'b0;
        issue(c, b);
        chk_b({tag, " sda hold"}, sda_oe, sda_before);
        tick();
        chk_b({tag, " sda drive"}, sda_oe, drv);
    endtask

    task automatic finish_bit();
        exp_t  e;
        string tag;
        logic  seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        e   = sb.pop_front();
        tag = sb_tag.pop_front();
        chk_b({tag, " rsp_valid seen"}, seen, 1'b1);
        if (seen) begin
            chk_b({tag, " rsp_bit"}, rsp_bit, e.rbit);
            chk_b({tag, " arb_lost"}, arb_lost, e.arb);
            chk_i({tag, " latency"}, cyc - acc_cyc, e.lat);
        end
    endtask

    initial begin
        int   n, m, k, ca, cb;
        logic busy_ok, act;

        rstb = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; cmd_bit = 1'b0;
        scl_hold = 1'b0; sda_hold = 1'b0;
        tlow = 8'(TL); thigh = 8'(TH); thold = 8'(THD);
        repeat (3) tick();
        chk_v("reset outputs", {1'b0, scl_oe, sda_oe, cmd_ready, rsp_valid, rsp_bit, arb_lost, busy},
              8'b0001_0000);
        rstb = 1'b1;
        repeat (3) tick();

        // First START: SDA low while SCL high for THIGH, then SCL low for THOLD.
        issue(CMD_START, 1'b0);
        chk_b("start busy", busy, 1'b1);
        n = 0;
        for (int i = 0; i < 100 && scl_oe !== 1'b1; i++) begin
            if (sda_oe === 1'b1) n++;
            tick();
        end
        chk_i("start sda low with scl high", n, TH);
        wait_ready();
        chk_i("start ready latency", cyc - acc_cyc, TH + THD);

        start_bit(CMD_WR, 1'b1, 1'b1, 1'b1, 1'b0, LAT, "wr1");
        finish_bit();
        start_bit(CMD_WR, 1'b0, 1'b0, 1'b0, 1'b0, LAT, "wr0");
        finish_bit();
        chk_b("scl low between bits", scl_oe, 1'b1);

        sda_hold = 1'b1;
        start_bit(CMD_RD, 1'b0, 1'b1, 1'b0, 1'b0, LAT, "rd sda low");
        finish_bit();
        sda_hold = 1'b0;
        start_bit(CMD_RD, 1'b0, 1'b0, 1'b1, 1'b0, LAT, "rd sda high");
        finish_bit();

        // Slave stretches SCL for 10 cycles past the DUT's release.
        scl_hold = 1'b1;
        start_bit(CMD_WR, 1'b0, 1'b0, 1'b0, 1'b0, LAT + 10, "stretch");
        for (int i = 0; i < 100 && scl_oe !== 1'b0; i++) tick();
        chk_b("stretch scl released", scl_oe, 1'b0);
        repeat (10) tick();
        scl_hold = 1'b0;
        finish_bit();

        // Repeated START: SDA up while SCL low, SCL high THIGH (+2 sync), SDA falls.
        issue(CMD_START, 1'b0);
        n = 0; m = 0; k = 0; busy_ok = 1'b1;
        for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (scl_oe === 1'b1 && sda_oe === 1'b0 && m == 0) n++;
            if (scl_oe === 1'b0 && sda_oe === 1'b0) m++;
            if (scl_oe === 1'b0 && sda_oe === 1'b1) k++;
            tick();
        end
        chk_i("rstart sda released scl low", n, TL);
        chk_i("rstart both released", m, TH + 2);
        chk_i("rstart sda low scl high", k, TH);
        chk_b("rstart busy held", busy_ok, 1'b1);
        chk_i("rstart ready latency", cyc - acc_cyc, TL + TH + 2 + TH + THD);

        // STOP: SDA release trails SCL release by THIGH plus the synchronizer delay.
        issue(CMD_STOP, 1'b0);
        ca = -1; cb = -1;
        for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) begin
            if (scl_oe === 1'b0 && ca < 0) ca = cyc;
            if (sda_oe === 1'b0 && cb < 0) cb = cyc;
            tick();
        end
        chk_i("stop sda rise after scl rise", cb - ca, TH + 2);
        chk_i("stop busy clear latency", cyc - acc_cyc, TL + TH + 2 + TH);
        chk_v("stop bus released", {5'b0, scl_oe, sda_oe, busy}, 8'b0);

        // Arbitration: another master pulls SDA low while we send a 1.
        issue(CMD_START, 1'b0);
        wait_ready();
        start_bit(CMD_WR, 1'b1, 1'b1, 1'b0, 1'b1, 9, "arb");
        for (int i = 0; i < 100 && scl_oe !== 1'b0; i++) tick();
        repeat (2) tick();
        sda_hold = 1'b1;
        finish_bit();
        chk_v("arb lines and busy", {5'b0, scl_oe, sda_oe, busy}, 8'b0);
        sda_hold = 1'b0;
        tick();

        // WR while not owning the bus is swallowed.
        issue(CMD_WR, 1'b0);
        chk_b("dropped wr ready", cmd_ready, 1'b1);
        act = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) act = 1'b1;
            tick();
        end
        chk_b("dropped wr no activity", act, 1'b0);

        // Reset in the middle of BIT_LOW releases both lines without a clock edge.
        issue(CMD_START, 1'b0);
        wait_ready();
        issue(CMD_WR, 1'b0);
        tick();
        chk_v("mid-bit enables", {6'b0, scl_oe, sda_oe}, 8'b0000_0011);
        #2;
        rstb = 1'b0;
        #1;
        chk_v("async reset enables", {6'b0, scl_oe, sda_oe}, 8'b0);
        repeat (2) tick();
        rstb = 1'b1;
        tick();
        chk_v("post-reset outputs", {1'b0, scl_oe, sda_oe, cmd_ready, rsp_valid, rsp_bit, arb_lost, busy},
              8'b0001_0000);
        issue(CMD_WR, 1'b1);
        act = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid !== 1'b0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) act = 1'b1;
            tick();
        end
        chk_b("post-reset wr dropped", act, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
